serial_add: RTL and testbench
=============================

SERIAL_ADD -- requirements
Module: serial_add

Interface
REQ-001 The parameter WIDTH SHALL default to 32 and set the operand and result width in bits.
REQ-002 The parameter CHUNK SHALL default to 8 and set the bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK, and K = WIDTH/CHUNK.
REQ-003 clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  is the asynchronous, active-low reset.
REQ-005 start  input  1  is the operation request, sampled only in IDLE or DONE.
REQ-006 mode  input  2  selects the operation: 00 = add, 01 = subtract, 10 = accumulate, 11 = add.
REQ-007 a  input  WIDTH  is operand A.
REQ-008 b  input  WIDTH  is operand B.
REQ-009 cin  input  1  is the carry-in for add and accumulate.
REQ-010 busy  output  1  is high while an operation is in progress.
REQ-011 done  output  1  is a one-cycle pulse marking valid new results.
REQ-012 z  output  WIDTH  is the registered sum/difference.
REQ-013 cout  output  1  is the carry-out of the MSB; for subtract, 1 = no borrow.
REQ-014 ovf  output  1  is the two's-complement signed overflow of the completed operation.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, RUN and DONE.
REQ-016 In IDLE or DONE, start=1 at a rising edge SHALL capture a, b, cin and mode into internal registers, clear the chunk index, and enter RUN.
REQ-017 Capture operand X SHALL be a for add and subtract, and the accumulator register for accumulate.
REQ-018 Capture operand Y SHALL be b for add, ~b for subtract, and a for accumulate.
REQ-019 Initial carry SHALL be cin for add and accumulate, and 1 for subtract; in subtract, cin SHALL be ignored.
REQ-020 Each rising edge in RUN SHALL add chunk i of X, chunk i of Y and the carry register.
  - CHUNK-bit result written to bits [i*CHUNK +: CHUNK] of the result shift/assembly register.
  - Carry-out stored for chunk i+1.
  - i increments; chunks processed LSB first.
REQ-021 After the K-th RUN edge, the FSM SHALL enter DONE, with done=1 and busy=0 for exactly that one cycle.
  - z, cout and ovf update at that same edge.
  - Total latency from the start-sampling edge to done visible SHALL be K+1 edges.
REQ-022 ovf SHALL equal the carry into the MSB XOR the carry out of the MSB, computed on the final chunk.
REQ-023 From DONE with start=0, the FSM SHALL return to IDLE on the next edge.
REQ-024 From DONE with start=1, the FSM SHALL accept the new operation directly (back-to-back, no idle cycle).
REQ-025 z, cout and ovf SHALL hold their values until the next completion; only done is a pulse.
REQ-026 busy SHALL be 1 in RUN and 0 in IDLE and DONE.
REQ-027 start while busy=1 SHALL be ignored and leave the operation in progress and its captured operands unaffected.
REQ-028 Input changes on a, b, cin and mode after capture SHALL NOT affect the operation in progress.
REQ-029 In accumulate mode, the accumulator register SHALL be loaded with the final z at completion.
  - Non-accumulate operations SHALL NOT modify the accumulator.
REQ-030 When K=1, the block SHALL complete in a single RUN edge (done on the second edge after start).
REQ-031 Arithmetic SHALL be modulo 2^WIDTH; there is no saturation.

Reset
REQ-032 rst_n=0 SHALL immediately, without a clock, force:
  - state to IDLE;
  - busy, done, z, cout and ovf to 0;
  - the accumulator, chunk index and carry registers to 0.
REQ-033 Reset asserted mid-RUN SHALL abandon the operation; outputs SHALL NOT update and done SHALL NOT pulse for it.
REQ-034 The first start sampled after rst_n deasserts SHALL be accepted normally.

Verification (WIDTH=8, CHUNK=4, K=2)
REQ-035 Add carry-out: mode=00, a=0xFF, b=0x01, cin=0, start pulse.
  - busy=1 for 2 cycles.
  - Then done=1, z=0x00, cout=1, ovf=0.
REQ-036 Subtract with borrow: mode=01, a=0x10, b=0x20, cin=1.
  - z=0xF0, cout=0, ovf=0 (cin ignored).
REQ-037 Signed overflow: mode=00, a=0x7F, b=0x01, cin=0.
  - z=0x80, cout=0, ovf=1.
REQ-038 Accumulate: after reset, three back-to-back operations with mode=10, a=0x05, cin=0, each started in the DONE cycle of the previous.
  - Successive done pulses show z=0x05, 0x0A, 0x0F.
  - No IDLE cycle between operations.
REQ-039 Start while busy: start pulse with a=0x01, b=0x01, then on the next edge (busy=1) start with a=0x40, b=0x40.
  - Second start ignored.
  - Single done pulse with z=0x02.
REQ-040 Reset mid-operation: rst_n low during RUN of 0x30+0x30.
  - Outputs go to 0 immediately and no done pulse follows.
  - After release, 0x03+0x04 yields z=0x07 with done at the expected K+1 edges.

Source files
------------

// File: rtl/serial_add.sv
// Chunk-serial adder/subtractor/accumulator: adds CHUNK bits per clock, LSB chunk first,
// and presents registered z/cout/ovf with a one-cycle done pulse after K = WIDTH/CHUNK cycles.
module serial_add #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned K    = WIDTH / CHUNK;
    localparam int unsigned IdxW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  x_q, x_d;
    logic [WIDTH-1:0]  y_q, y_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  z_q, z_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              acc_op_q, acc_op_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [CHUNK-1:0]  chunk_x, chunk_y;
    logic [CHUNK:0]    chunk_sum;
    logic [WIDTH-1:0]  res_next;
    logic              last_chunk;
    logic              msb_carry_in;

    // Datapath for the chunk selected by idx_q.
    always_comb begin
        chunk_x  = '0;
        chunk_y  = '0;
        for (int k = 0; k < int'(K); k++) begin
            if (idx_q == IdxW'(k)) begin
                chunk_x = x_q[k*CHUNK +: CHUNK];
                chunk_y = y_q[k*CHUNK +: CHUNK];
            end
        end
        chunk_sum = {1'b0, chunk_x} + {1'b0, chunk_y} + {{CHUNK{1'b0}}, carry_q};
        res_next  = res_q;
        for (int k = 0; k < int'(K); k++) begin
            if (idx_q == IdxW'(k)) begin
                res_next[k*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
            end
        end
        last_chunk   = (idx_q == IdxW'(K - 1));
        // Carry into the top bit recovered from its sum bit and the two operand bits.
        msb_carry_in = chunk_sum[CHUNK-1] ^ chunk_x[CHUNK-1] ^ chunk_y[CHUNK-1];
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        res_d    = res_q;
        acc_d    = acc_q;
        z_d      = z_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        acc_op_d = acc_op_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d  = StRun;
                    idx_d    = '0;
                    res_d    = '0;
                    acc_op_d = (mode == 2'b10);
                    case (mode)
                        2'b01: begin
                            x_d     = a;
                            y_d     = ~b;
                            carry_d = 1'b1;
                        end
                        2'b10: begin
                            x_d     = acc_q;
                            y_d     = a;
                            carry_d = cin;
                        end
                        default: begin
                            x_d     = a;
                            y_d     = b;
                            carry_d = cin;
                        end
                    endcase
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                res_d   = res_next;
                carry_d = chunk_sum[CHUNK];
                idx_d   = idx_q + 1'b1;
                if (last_chunk) begin
                    state_d = StDone;
                    z_d     = res_next;
                    cout_d  = chunk_sum[CHUNK];
                    ovf_d   = msb_carry_in ^ chunk_sum[CHUNK];
                    if (acc_op_q) begin
                        acc_d = res_next;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StRun);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            x_q      <= '0;
            y_q      <= '0;
            res_q    <= '0;
            acc_q    <= '0;
            z_q      <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            acc_op_q <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            res_q    <= res_d;
            acc_q    <= acc_d;
            z_q      <= z_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            acc_op_q <= acc_op_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign z    = z_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add.sv
// Scoreboard bench for serial_add at WIDTH=8, CHUNK=4: a reference model pushes expected
// results on each start, and a done monitor pops and compares them.
module tb_serial_add;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CHUNK = 4;

    typedef struct packed {
        logic [7:0] z;
        logic       cout;
        logic       ovf;
    } res_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] z;
    logic             cout;
    logic             ovf;

    res_t       exp_q[$];
    logic [7:0] acc_m;
    int         n_checks;
    int         n_bad;

    serial_add #(
        .WIDTH(WIDTH),
        .CHUNK(CHUNK)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .mode (mode),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .z    (z),
        .cout (cout),
        .ovf  (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model; also tracks the accumulator.
    function automatic res_t model(input logic [1:0] m, input logic [7:0] av, input logic [7:0] bv,
                                   input logic ci);
        logic [7:0] x, y;
        logic       c;
        logic [8:0] full;
        res_t       r;
        x    = (m == 2'b10) ? acc_m : av;
        y    = (m == 2'b01) ? ~bv : ((m == 2'b10) ? av : bv);
        c    = (m == 2'b01) ? 1'b1 : ci;
        full = {1'b0, x} + {1'b0, y} + {8'b0, c};
        r.z    = full[7:0];
        r.cout = full[8];
        r.ovf  = (x[7] == y[7]) && (full[7] != x[7]);
        if (m == 2'b10) acc_m = full[7:0];
        return r;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_done", 32'(done), 32'd0);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                check_eq("sb_z", 32'(z), 32'(e.z));
                check_eq("sb_cout", 32'(cout), 32'(e.cout));
                check_eq("sb_ovf", 32'(ovf), 32'(e.ovf));
            end
        end
    end

    // Start one operation, scramble inputs after capture, and check the busy/done timeline.
    task automatic run_op(input logic [1:0] m, input logic [7:0] av, input logic [7:0] bv,
                          input logic ci, input string tag);
        @(negedge clk);
        mode  = m;
        a     = av;
        b     = bv;
        cin   = ci;
        start = 1'b1;
        exp_q.push_back(model(m, av, bv, ci));
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        cin   = 1'($urandom);
        mode  = 2'($urandom);
        check_eq({tag, "_busy_c1"}, 32'(busy), 32'd1);
        check_eq({tag, "_done_c1"}, 32'(done), 32'd0);
        @(posedge clk);
        #1;
        check_eq({tag, "_busy_c2"}, 32'(busy), 32'd1);
        check_eq({tag, "_done_c2"}, 32'(done), 32'd0);
        @(posedge clk);
        #1;
        check_eq({tag, "_done_c3"}, 32'(done), 32'd1);
        check_eq({tag, "_busy_c3"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_bad    = 0;
        acc_m    = 8'h00;
        rst_n    = 1'b0;
        start    = 1'b0;
        mode     = 2'b00;
        a        = 8'h00;
        b        = 8'h00;
        cin      = 1'b0;
        #3;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_z", 32'(z), 32'd0);
        check_eq("rst_cout", 32'(cout), 32'd0);
        check_eq("rst_ovf", 32'(ovf), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back accumulate, each started in the previous DONE cycle.
        run_op(2'b10, 8'h05, 8'h00, 1'b0, "acc1");
        check_eq("acc1_z", 32'(z), 32'h05);
        run_op(2'b10, 8'h05, 8'h00, 1'b0, "acc2");
        check_eq("acc2_z", 32'(z), 32'h0A);
        run_op(2'b10, 8'h05, 8'h00, 1'b0, "acc3");
        check_eq("acc3_z", 32'(z), 32'h0F);
        @(posedge clk);
        #1;
        check_eq("done_to_idle_busy", 32'(busy), 32'd0);
        check_eq("done_pulse_width", 32'(done), 32'd0);
        check_eq("hold_z", 32'(z), 32'h0F);

        repeat (2) @(posedge clk);
        run_op(2'b00, 8'hFF, 8'h01, 1'b0, "add_cy");
        check_eq("add_cy_z", 32'(z), 32'h00);
        check_eq("add_cy_cout", 32'(cout), 32'd1);
        check_eq("add_cy_ovf", 32'(ovf), 32'd0);

        run_op(2'b01, 8'h10, 8'h20, 1'b1, "sub_bw");
        check_eq("sub_bw_z", 32'(z), 32'hF0);
        check_eq("sub_bw_cout", 32'(cout), 32'd0);
        check_eq("sub_bw_ovf", 32'(ovf), 32'd0);

        run_op(2'b00, 8'h7F, 8'h01, 1'b0, "sovf");
        check_eq("sovf_z", 32'(z), 32'h80);
        check_eq("sovf_cout", 32'(cout), 32'd0);
        check_eq("sovf_ovf", 32'(ovf), 32'd1);

        // Accumulator untouched by the non-accumulate operations above.
        run_op(2'b10, 8'h01, 8'h00, 1'b0, "acc4");
        check_eq("acc4_z", 32'(z), 32'h10);

        // Start while busy must be ignored.
        @(negedge clk);
        mode  = 2'b00;
        a     = 8'h01;
        b     = 8'h01;
        cin   = 1'b0;
        start = 1'b1;
        exp_q.push_back(model(2'b00, 8'h01, 8'h01, 1'b0));
        @(posedge clk);
        #1;
        a = 8'h40;
        b = 8'h40;
        check_eq("bs_busy_c1", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("bs_busy_c2", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        check_eq("bs_done", 32'(done), 32'd1);
        check_eq("bs_z", 32'(z), 32'h02);
        repeat (4) @(posedge clk);
        #1;
        check_eq("bs_no_second_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_op(2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), "rnd");
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        // Reset mid-operation abandons it.
        @(negedge clk);
        mode  = 2'b00;
        a     = 8'h30;
        b     = 8'h30;
        cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("rmid_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        acc_m = 8'h00;
        #1;
        check_eq("rmid_busy0", 32'(busy), 32'd0);
        check_eq("rmid_done0", 32'(done), 32'd0);
        check_eq("rmid_z0", 32'(z), 32'd0);
        check_eq("rmid_cout0", 32'(cout), 32'd0);
        check_eq("rmid_ovf0", 32'(ovf), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rmid_no_done", 32'(done), 32'd0);
        check_eq("rmid_z_held", 32'(z), 32'd0);
        run_op(2'b00, 8'h03, 8'h04, 1'b0, "post_rst");
        check_eq("post_rst_z", 32'(z), 32'h07);
        repeat (2) @(posedge clk);
        run_op(2'b10, 8'h09, 8'h00, 1'b0, "acc_clr");
        check_eq("acc_clr_z", 32'(z), 32'h09);

        repeat (3) @(posedge clk);
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
